// File: rtl/sand_pkg.sv
// rtl/sand_pkg.sv - material codes and brush FSM state type for the sand playfield
// Ports: none (package).
package sand_pkg;

  localparam logic [1:0] MAT_EMPTY = 2'd0;
  localparam logic [1:0] MAT_SAND  = 2'd1;
  localparam logic [1:0] MAT_WALL  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    COOL  = 2'd2
  } brush_state_t;

endpackage

// File: rtl/brush_scanner.sv
// rtl/brush_scanner.sv - walks a clipped square brush row-major, one cell per step
// Ports:
//   clk_i, reset_i       clock, asynchronous active-low reset
//   start_i              latch origin/size from x_i/y_i/size_i
//   step_i               present the current cell and advance to the next
//   x_i, y_i, size_i     brush centre and requested edge length
//   cell_valid_o         a cell is presented this cycle
//   in_bounds_o          presented cell lies inside the playfield
//   address_o            RAM address of presented cell (meaningful when in bounds)
//   last_o               presented cell is the final one of the stroke
module brush_scanner #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 400,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int MAX_BRUSH      = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                start_i,
  input  logic                                step_i,
  input  logic [$clog2(ACTIVE_COLUMNS)-1:0]   x_i,
  input  logic [$clog2(ACTIVE_ROWS)-1:0]      y_i,
  input  logic [$clog2(MAX_BRUSH+1)-1:0]      size_i,
  output logic                                cell_valid_o,
  output logic                                in_bounds_o,
  output logic [ADDR_WIDTH-1:0]               address_o,
  output logic                                last_o
);

  localparam int CW = $clog2(ACTIVE_COLUMNS);
  localparam int RW = $clog2(ACTIVE_ROWS);
  localparam int SW = $clog2(MAX_BRUSH+1);
  // Two guard bits: origin can go negative and the far edge can pass the
  // coordinate range without the running counters wrapping.
  localparam int CX = CW + 2;
  localparam int RX = RW + 2;
  localparam int AX = CX + RX;

  localparam logic [SW-1:0]        MAX_S  = SW'(MAX_BRUSH);
  localparam logic signed [CX-1:0] COLS_C = CX'(ACTIVE_COLUMNS);
  localparam logic signed [RX-1:0] ROWS_R = RX'(ACTIVE_ROWS);
  localparam logic signed [AX-1:0] COLS_A = AX'(ACTIVE_COLUMNS);

  logic [SW-1:0]        size_eff, half;
  logic signed [CX-1:0] x0;
  logic signed [RX-1:0] y0;
  logic signed [AX-1:0] base0;

  logic signed [CX-1:0] x0_q, x0_d, col_q, col_d;
  logic signed [RX-1:0] row_q, row_d;
  logic signed [AX-1:0] base_q, base_d;
  logic [SW-1:0]        size_q, size_d, ci_q, ci_d, ri_q, ri_d;
  logic                 col_last, row_last;

  always_comb begin
    if (size_i == '0)        size_eff = SW'(1);
    else if (size_i > MAX_S) size_eff = MAX_S;
    else                     size_eff = size_i;
    half  = (size_eff - SW'(1)) >> 1;
    x0    = $signed({2'b00, x_i}) - $signed(CX'(half));
    y0    = $signed({2'b00, y_i}) - $signed(RX'(half));
    // Only multiply is at latch time; the scan loop itself just adds.
    base0 = AX'(y0) * COLS_A;
  end

  assign col_last = (ci_q == size_q - SW'(1));
  assign row_last = (ri_q == size_q - SW'(1));

  always_comb begin
    x0_d   = x0_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    size_d = size_q;
    ci_d   = ci_q;
    ri_d   = ri_q;
    if (start_i) begin
      x0_d   = x0;
      col_d  = x0;
      row_d  = y0;
      base_d = base0;
      size_d = size_eff;
      ci_d   = '0;
      ri_d   = '0;
    end else if (step_i) begin
      if (col_last) begin
        ci_d   = '0;
        col_d  = x0_q;
        ri_d   = ri_q + SW'(1);
        row_d  = row_q + RX'(1);
        base_d = base_q + COLS_A;
      end else begin
        ci_d  = ci_q + SW'(1);
        col_d = col_q + CX'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      x0_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      size_q <= '0;
      ci_q   <= '0;
      ri_q   <= '0;
    end else begin
      x0_q   <= x0_d;
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      size_q <= size_d;
      ci_q   <= ci_d;
      ri_q   <= ri_d;
    end
  end

  assign cell_valid_o = step_i;
  assign in_bounds_o  = !col_q[CX-1] && (col_q < COLS_C) && !row_q[RX-1] && (row_q < ROWS_R);
  assign address_o    = ADDR_WIDTH'(base_q + AX'(col_q));
  assign last_o       = step_i && col_last && row_last;

endmodule

// File: rtl/sand_brush_write_arbiter.sv
// rtl/sand_brush_write_arbiter.sv - brush rasteriser arbitrated against game-state writes
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-low reset
//   brush_req_i, brush_x_i, brush_y_i   stroke request and centre
//   brush_size_i, brush_material_i      edge length and material to paint
//   brush_busy_o                        high while painting
//   gs_wr_valid_i/_ready_o/_address_i/_data_i  game-state write handshake
//   ram_wr_en_o/_address_o/_data_o      registered RAM write port
module sand_brush_write_arbiter #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 400,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int MAX_BRUSH      = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              brush_req_i,
  input  logic [$clog2(ACTIVE_COLUMNS)-1:0] brush_x_i,
  input  logic [$clog2(ACTIVE_ROWS)-1:0]    brush_y_i,
  input  logic [$clog2(MAX_BRUSH+1)-1:0]    brush_size_i,
  input  logic [DATA_WIDTH-1:0]             brush_material_i,
  output logic                              brush_busy_o,
  input  logic                              gs_wr_valid_i,
  output logic                              gs_wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]             gs_wr_address_i,
  input  logic [DATA_WIDTH-1:0]             gs_wr_data_i,
  output logic                              ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]             ram_wr_address_o,
  output logic [DATA_WIDTH-1:0]             ram_wr_data_o
);
  import sand_pkg::*;

  brush_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] mat_q, mat_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  start, painting;
  logic                  scan_valid, scan_in_bounds, scan_last;
  logic [ADDR_WIDTH-1:0] scan_addr;

  assign painting = (state_q == PAINT);
  assign start    = (state_q == IDLE) && brush_req_i;

  brush_scanner #(
    .ACTIVE_COLUMNS(ACTIVE_COLUMNS),
    .ACTIVE_ROWS   (ACTIVE_ROWS),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MAX_BRUSH     (MAX_BRUSH)
  ) u_scanner (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start),
    .step_i      (painting),
    .x_i         (brush_x_i),
    .y_i         (brush_y_i),
    .size_i      (brush_size_i),
    .cell_valid_o(scan_valid),
    .in_bounds_o (scan_in_bounds),
    .address_o   (scan_addr),
    .last_o      (scan_last)
  );

  always_comb begin
    state_d = state_q;
    mat_d   = start ? brush_material_i : mat_q;
    case (state_q)
      IDLE:    if (brush_req_i) state_d = PAINT;
      PAINT:   if (scan_last)   state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Brush owns the port for the whole stroke; a game write waiting here
  // is simply not acknowledged until COOL/IDLE.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (painting) begin
      if (scan_valid && scan_in_bounds) begin
        wr_en_d   = 1'b1;
        wr_addr_d = scan_addr;
        wr_data_d = mat_q;
      end
    end else if (gs_wr_valid_i) begin
      wr_en_d   = 1'b1;
      wr_addr_d = gs_wr_address_i;
      wr_data_d = gs_wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      mat_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign brush_busy_o     = painting;
  assign gs_wr_ready_o    = !painting;
  assign ram_wr_en_o      = wr_en_q;
  assign ram_wr_address_o = wr_addr_q;
  assign ram_wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_sand_brush_write_arbiter.sv
// tb/tb_sand_brush_write_arbiter.sv - bench for sand_brush_write_arbiter
module tb_sand_brush_write_arbiter;

  localparam int COLS = 640;
  localparam int ROWS = 400;
  localparam int AW   = $clog2(COLS*ROWS);
  localparam int DW   = 2;
  localparam int MB   = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          brush_req_i;
  logic [9:0]    brush_x_i;
  logic [8:0]    brush_y_i;
  logic [3:0]    brush_size_i;
  logic [DW-1:0] brush_material_i;
  logic          brush_busy_o;
  logic          gs_wr_valid_i;
  logic          gs_wr_ready_o;
  logic [AW-1:0] gs_wr_address_i;
  logic [DW-1:0] gs_wr_data_i;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_address_o;
  logic [DW-1:0] ram_wr_data_o;

  always #5 clk = ~clk;

  sand_brush_write_arbiter #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MAX_BRUSH(MB)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .brush_req_i(brush_req_i), .brush_x_i(brush_x_i), .brush_y_i(brush_y_i),
    .brush_size_i(brush_size_i), .brush_material_i(brush_material_i),
    .brush_busy_o(brush_busy_o),
    .gs_wr_valid_i(gs_wr_valid_i), .gs_wr_ready_o(gs_wr_ready_o),
    .gs_wr_address_i(gs_wr_address_i), .gs_wr_data_i(gs_wr_data_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_address_o(ram_wr_address_o),
    .ram_wr_data_o(ram_wr_data_o)
  );

  typedef struct { bit en; int addr; int data; } cell_t;
  typedef struct { int addr; int data; } wr_t;

  cell_t cells[$];
  wr_t   writes[$];
  bit    cool;
  bit    exp_en;
  int    exp_addr, exp_data;
  int    n_checks, n_fail;
  int    busy_cnt, rdy_low_cnt;
  bit    acc_prev;
  bit    m_busy;
  cell_t m_cell;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every cell the stroke covers, in visiting order, straight from geometry.
  task automatic gen_stroke(int x, int y, int size, int mat);
    int s, x0, y0, col, row;
    cell_t c;
    s  = (size == 0) ? 1 : (size > MB) ? MB : size;
    x0 = x - (s - 1) / 2;
    y0 = y - (s - 1) / 2;
    for (int r = 0; r < s; r++) begin
      for (int k = 0; k < s; k++) begin
        col    = x0 + k;
        row    = y0 + r;
        c.en   = (col >= 0) && (col < COLS) && (row >= 0) && (row < ROWS);
        c.addr = row * COLS + col;
        c.data = mat;
        cells.push_back(c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      check("rst_en", ram_wr_en_o, 0);
      check("rst_addr", ram_wr_address_o, 0);
      check("rst_data", ram_wr_data_o, 0);
      check("rst_busy", brush_busy_o, 0);
      check("rst_ready", gs_wr_ready_o, 1);
      cells.delete();
      cool     = 0;
      exp_en   = 0;
      acc_prev = 0;
    end else begin
      m_busy = (cells.size() != 0);
      check("busy", brush_busy_o, m_busy);
      check("ready", gs_wr_ready_o, !m_busy);
      check("wr_en", ram_wr_en_o, exp_en);
      if (exp_en) begin
        check("wr_addr", ram_wr_address_o, exp_addr);
        check("wr_data", ram_wr_data_o, exp_data);
      end
      if (ram_wr_en_o) writes.push_back('{int'(ram_wr_address_o), int'(ram_wr_data_o)});
      if (brush_busy_o) busy_cnt++;
      if (!gs_wr_ready_o) rdy_low_cnt++;
      acc_prev = gs_wr_valid_i && gs_wr_ready_o;
      if (m_busy) begin
        m_cell = cells.pop_front();
        exp_en = m_cell.en;
        if (m_cell.en) begin
          exp_addr = m_cell.addr;
          exp_data = m_cell.data;
        end
        if (cells.size() == 0) cool = 1;
      end else begin
        exp_en = gs_wr_valid_i;
        if (gs_wr_valid_i) begin
          exp_addr = int'(gs_wr_address_i);
          exp_data = int'(gs_wr_data_i);
        end
        if (cool) cool = 0;
        else if (brush_req_i)
          gen_stroke(int'(brush_x_i), int'(brush_y_i), int'(brush_size_i), int'(brush_material_i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    brush_req_i = 0;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    writes.delete();
    busy_cnt    = 0;
    rdy_low_cnt = 0;
  endtask

  task automatic stroke(int x, int y, int size, int mat);
    brush_x_i        = 10'(x);
    brush_y_i        = 9'(y);
    brush_size_i     = 4'(size);
    brush_material_i = 2'(mat);
    brush_req_i      = 1;
    tick();
    brush_req_i = 0;
  endtask

  int exp3[4];

  initial begin
    n_checks = 0; n_fail = 0;
    reset_i = 0; brush_req_i = 0; brush_x_i = 0; brush_y_i = 0;
    brush_size_i = 0; brush_material_i = 0;
    gs_wr_valid_i = 0; gs_wr_address_i = 0; gs_wr_data_i = 0;
    clear_log();
    repeat (3) tick();
    reset_i = 1;
    idle(2);

    // size 1 at (10,20)
    clear_log();
    stroke(10, 20, 1, 1);
    idle(5);
    check("s1_count", writes.size(), 1);
    if (writes.size() >= 1) begin
      check("s1_addr", writes[0].addr, 12810);
      check("s1_data", writes[0].data, 1);
    end
    check("s1_busy_cycles", busy_cnt, 1);
    check("s1_ready_low", rdy_low_cnt, 1);

    // size 3 at (0,0): clipped corner
    clear_log();
    stroke(0, 0, 3, 2);
    idle(14);
    exp3 = '{0, 1, 640, 641};
    check("s3_count", writes.size(), 4);
    for (int i = 0; i < 4 && i < writes.size(); i++) check("s3_addr", writes[i].addr, exp3[i]);
    check("s3_busy_cycles", busy_cnt, 9);

    // size 2 at far corner
    clear_log();
    stroke(639, 399, 2, 3);
    idle(8);
    check("s2_count", writes.size(), 1);
    if (writes.size() >= 1) check("s2_addr", writes[0].addr, 255999);
    check("s2_busy_cycles", busy_cnt, 4);

    // game write held during a stroke
    clear_log();
    stroke(100, 100, 3, 1);
    gs_wr_valid_i = 1; gs_wr_address_i = 1000; gs_wr_data_i = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_prev) gs_wr_valid_i = 0;
    end
    check("gs_released", gs_wr_valid_i, 0);
    check("gs_ready_low", rdy_low_cnt, 9);
    check("gs_count", writes.size(), 10);
    if (writes.size() == 10) begin
      check("gs_addr", writes[9].addr, 1000);
      check("gs_data", writes[9].data, 2);
    end

    // size 0 and oversize
    clear_log();
    stroke(10, 20, 0, 1);
    idle(5);
    check("sz0_busy", busy_cnt, 1);
    check("sz0_count", writes.size(), 1);
    clear_log();
    stroke(320, 200, 15, 1);
    idle(70);
    check("sz15_busy", busy_cnt, 64);
    check("sz15_count", writes.size(), 64);

    // reset in the 4th PAINT cycle of a size-4 stroke
    stroke(50, 50, 4, 2);
    repeat (3) tick();
    reset_i = 0;
    #1;
    check("mid_rst_en", ram_wr_en_o, 0);
    check("mid_rst_busy", brush_busy_o, 0);
    tick();
    reset_i = 1;
    clear_log();
    idle(25);
    check("post_rst_writes", writes.size(), 0);
    check("post_rst_busy", busy_cnt, 0);

    // randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 600; i++) begin
      brush_req_i      = ($urandom % 10) == 0;
      brush_x_i        = 10'($urandom_range(0, COLS - 1));
      brush_y_i        = 9'($urandom_range(0, ROWS - 1));
      brush_size_i     = 4'($urandom % 16);
      brush_material_i = 2'($urandom % 4);
      if (!gs_wr_valid_i || acc_prev) begin
        gs_wr_valid_i   = ($urandom % 3) == 0;
        gs_wr_address_i = AW'($urandom_range(0, COLS * ROWS - 1));
        gs_wr_data_i    = 2'($urandom % 4);
      end
      tick();
    end
    brush_req_i = 0;
    for (int i = 0; i < 80; i++) begin
      if (acc_prev) gs_wr_valid_i = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sand_brush_write_arbiter.md
# sand_brush_write_arbiter

Parametrised write-port arbiter and brush rasteriser for the game-state RAM. It replaces the single-pixel cursor-draw mux in front of the game-state RAM. It rasterises a clipped square brush of runtime-selectable size and material, and arbitrates that brush against the game-state controller over a valid/ready handshake, so game-state writes are stalled rather than dropped. It sits between `game_state_controller` / mouse tracking and the game-state RAM write port.

## Interface
- `ACTIVE_COLUMNS`, 640: playfield width in pixels.
- `ACTIVE_ROWS`, 400: playfield height in pixels.
- `ADDR_WIDTH`, `$clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)`: RAM address width.
- `DATA_WIDTH`, 2: material code width.
- `MAX_BRUSH`, 8: largest brush edge length in pixels (≥1).
- `clk_i` input 1: single clock.
- `reset_i` input 1: asynchronous, active-low reset.
- `brush_req_i` input 1: level; request a stroke.
- `brush_x_i` input `$clog2(ACTIVE_COLUMNS)`: brush centre column.
- `brush_y_i` input `$clog2(ACTIVE_ROWS)`: brush centre row.
- `brush_size_i` input `$clog2(MAX_BRUSH+1)`: edge length.
- `brush_material_i` input `DATA_WIDTH`: material code to paint.
- `brush_busy_o` output 1: high while in PAINT.
- `gs_wr_valid_i` input 1: game-state write request.
- `gs_wr_ready_o` output 1: game-state write accepted when valid & ready.
- `gs_wr_address_i` input `ADDR_WIDTH`: game-state write address.
- `gs_wr_data_i` input `DATA_WIDTH`: game-state write data.
- `ram_wr_en_o` output 1: registered RAM write enable.
- `ram_wr_address_o` output `ADDR_WIDTH`: registered RAM write address.
- `ram_wr_data_o` output `DATA_WIDTH`: registered RAM write data.

## Operation
- FSM states: IDLE, PAINT, COOL.
  - IDLE → PAINT when `brush_req_i`=1.
  - PAINT → COOL after the last brush cell.
  - COOL → IDLE unconditionally.
- Stroke parameters are latched on the IDLE→PAINT edge. Input changes during PAINT are ignored.
- Effective size S:
  - `brush_size_i`=0 → S=1.
  - `brush_size_i` > MAX_BRUSH → S=MAX_BRUSH.
  - Otherwise S=`brush_size_i`.
- Top-left corner: (x0,y0) = (x−(S−1)/2, y−(S−1)/2). Use integer division and signed arithmetic one bit wider than the coordinate.
- PAINT visits exactly S×S cells, one per cycle, row-major: column index increments first, then row index.
- A cell with col<0, col≥ACTIVE_COLUMNS, row<0 or row≥ACTIVE_ROWS still consumes its cycle but produces no write.
- In-bounds cell address = row×ACTIVE_COLUMNS+col. It is computed incrementally (row base + column), with no multiplier in the loop.
- `gs_wr_ready_o` = (state != PAINT). The brush always has priority.
- COOL guarantees at least one game-state slot between back-to-back strokes.
- A game write accepted in IDLE or COOL is forwarded. A held request during PAINT stays pending: the upstream controller keeps valid/address/data stable until it is accepted.
- `brush_busy_o` = (state == PAINT).

## Timing
- Reset values:
  - `ram_wr_en_o`=0, `ram_wr_address_o`=0, `ram_wr_data_o`=0.
  - `brush_busy_o`=0.
  - `gs_wr_ready_o`=1 (state IDLE).
- Latency from game write accepted in cycle N to `ram_wr_*` valid in cycle N+1.
- Latency from brush cell visited in PAINT cycle k to `ram_wr_*` in cycle k+1. `ram_wr_en_o` is 0 for clipped cells.
- Stroke timeline:
  - `brush_req_i` sampled high in cycle 0.
  - PAINT cycles 1..S².
  - COOL in cycle S²+1.
  - IDLE in cycle S²+2.
- `ram_wr_en_o` is low in any cycle that had no accepted write or in-bounds cell in the previous cycle.
- Reset asserted mid-stroke: the FSM goes to IDLE immediately and the output register clears. The stroke is not resumed after reset.

## Structure
- `sand_pkg`:
  - Material constants: `MAT_EMPTY`=0, `MAT_SAND`=1, `MAT_WALL`=2.
  - `brush_state_t` enum {IDLE, PAINT, COOL}.
- Sub-module `brush_scanner`:
  - Holds the latched origin and size, plus the column/row counters and the incremental address.
  - Outputs per cycle: `cell_valid`, `in_bounds`, `address`, `last`.
- The arbiter, FSM and output register stay in the top of this block.

## Test plan
Parameters for all scenarios: COLUMNS=640, ROWS=400, DATA_WIDTH=2, MAX_BRUSH=8.
- Size 1 at (10,20), material 1, request in cycle 0 → one write in cycle 2: addr 12810, data 1. `gs_wr_ready_o` is 0 only in cycle 1.
- Size 3 at (0,0) → 9 PAINT cycles. Writes only to addrs 0, 1, 640, 641, in that order; 5 clipped cycles have en=0.
- Size 2 at (639,399) → origin (639,399). Exactly one write, addr 255999; 3 clipped cycles.
- `gs_wr_valid_i` held with addr 1000, data 2 during a size-3 stroke → ready low for 9 cycles. Accepted in the COOL cycle and written once, in the cycle after COOL; no loss and no duplicate.
- `brush_size_i`=0 behaves as size 1, and `brush_size_i`=15 behaves as size 8: 64 PAINT cycles.
- `reset_i` low in the 4th PAINT cycle of a size-4 stroke → `ram_wr_en_o`=0 and `brush_busy_o`=0 immediately. No further writes after release unless `brush_req_i` is re-asserted.
